// File: rtl/divmult_pkg.sv
// Shared definitions for the iterative signed multiply/divide sequencer.
//   DM_WIDTH / DM_CNT_W : default operand width and iteration-counter width
//   OP_MULT / OP_DIV    : encoding of the op input
//   dm_state_e          : sequencer FSM states
package divmult_pkg;

    localparam int DM_WIDTH = 32;
    localparam int DM_CNT_W = 6;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2,
        DONE   = 2'd3
    } dm_state_e;

endpackage

// File: rtl/divmult_sequencer.sv
// Iterative signed multiply/divide unit feeding the HI/LO registers of the
// multicycle CPU. One operation at a time, one bit per cycle, fixed latency.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    request pulse, only honoured in IDLE
//   op       0 = MULT, 1 = DIV (sampled with start)
//   a, b     signed operands (multiplicand/dividend, multiplier/divisor)
//   busy     high from the cycle after accept through FINISH
//   done     one-cycle pulse when hi/lo/div_zero are valid
//   hi, lo   MULT: product high/low word; DIV: remainder/quotient
//   div_zero DIV with b == 0; held until the next accepted start
module divmult_sequencer
    import divmult_pkg::*;
#(
    parameter int WIDTH = DM_WIDTH,
    parameter int CNT_W = DM_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    dm_state_e              state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   op_r;
    logic                   sign_a_r;
    logic                   sign_b_r;
    // MULT: {partial product, remaining multiplier}; DIV: {remainder, quotient}
    logic [2*WIDTH-1:0]     acc_r;
    // MULT: |multiplicand|; DIV: |divisor|
    logic [WIDTH-1:0]       opnd_r;

    logic [WIDTH-1:0]       abs_a_s;
    logic [WIDTH-1:0]       abs_b_s;
    logic [WIDTH:0]         mul_sum_s;
    logic [WIDTH:0]         div_diff_s;
    logic [2*WIDTH-1:0]     acc_step_s;
    logic [2*WIDTH-1:0]     prod_fix_s;
    logic [WIDTH-1:0]       quo_fix_s;
    logic [WIDTH-1:0]       rem_fix_s;

    // Operand magnitudes; the most negative value maps onto itself, which is
    // still the correct unsigned magnitude.
    always_comb begin
        abs_a_s = a;
        abs_b_s = b;
        if (a[WIDTH-1]) begin
            abs_a_s = -a;
        end else begin
            abs_a_s = a;
        end
        if (b[WIDTH-1]) begin
            abs_b_s = -b;
        end else begin
            abs_b_s = b;
        end
    end

    // One iteration of shift-add multiply or restoring divide on the shared accumulator.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        div_diff_s = acc_r[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_r};
        acc_step_s = acc_r;
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
        end
        if (op_r == OP_DIV) begin
            // Borrow out means the shifted remainder is below the divisor: restore.
            if (div_diff_s[WIDTH]) begin
                acc_step_s = {acc_r[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_step_s = {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Carry of the partial sum lands in the top bit as everything shifts right.
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Sign correction of the unsigned result: quotient/product follow the
    // operand sign difference, remainder follows the dividend.
    always_comb begin
        prod_fix_s = acc_r;
        quo_fix_s  = acc_r[WIDTH-1:0];
        rem_fix_s  = acc_r[2*WIDTH-1:WIDTH];
        if (sign_a_r ^ sign_b_r) begin
            prod_fix_s = -acc_r;
            quo_fix_s  = -acc_r[WIDTH-1:0];
        end else begin
            prod_fix_s = acc_r;
            quo_fix_s  = acc_r[WIDTH-1:0];
        end
        if (sign_a_r) begin
            rem_fix_s = -acc_r[2*WIDTH-1:WIDTH];
        end else begin
            rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Sequencer FSM with its datapath registers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            op_r     <= OP_MULT;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            acc_r    <= {(2*WIDTH){1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= {WIDTH{1'b0}};
            lo       <= {WIDTH{1'b0}};
            div_zero <= 1'b0;
        end else begin
            // Outputs trail the state by one cycle so busy/done line up with
            // the fixed latency seen by the control unit.
            busy <= (state_r == CALC) || (state_r == FINISH);
            done <= (state_r == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        op_r     <= op;
                        sign_a_r <= a[WIDTH-1];
                        sign_b_r <= b[WIDTH-1];
                        cnt_r    <= {CNT_W{1'b0}};
                        div_zero <= 1'b0;
                        if ((op == OP_DIV) && (b == {WIDTH{1'b0}})) begin
                            // Skip the datapath entirely; hi/lo keep the last result.
                            div_zero <= 1'b1;
                            state_r  <= DONE;
                        end else if (op == OP_DIV) begin
                            acc_r   <= {{WIDTH{1'b0}}, abs_a_s};
                            opnd_r  <= abs_b_s;
                            state_r <= CALC;
                        end else begin
                            acc_r   <= {{WIDTH{1'b0}}, abs_b_s};
                            opnd_r  <= abs_a_s;
                            state_r <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= FINISH;
                    end
                end
                FINISH: begin
                    if (op_r == OP_DIV) begin
                        hi <= rem_fix_s;
                        lo <= quo_fix_s;
                    end else begin
                        hi <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo <= prod_fix_s[WIDTH-1:0];
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divmult_sequencer.sv
// Scoreboard bench for divmult_sequencer: the driver pushes hand-computed
// results, a negedge monitor pops and compares whenever done is seen.
module tb_divmult_sequencer;
    import divmult_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];

    divmult_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                e = sb_q.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("div_zero", div_zero, e.dz);
                chk("done_cycle", edge_cnt, e.cyc);
            end
        end
    end

    // Issue one operation (called at a negedge). poke_cyc >= 0 re-pulses start
    // in that cycle; rst_cyc >= 0 aborts with reset in that cycle.
    task automatic do_op(input logic o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                         input int poke_cyc, input int rst_cyc);
        int acc_e;
        int lat;
        lat = ((o == OP_DIV) && (vb == 32'd0)) ? 1 : 34;
        start = 1'b1; op = o; a = va; b = vb;
        acc_e = edge_cnt + 1;
        if (rst_cyc < 0) sb_q.push_back('{ehi, elo, edz, acc_e + lat});
        @(negedge clk);
        start = 1'b0; op = ~o; a = 32'h1234_5678; b = 32'd0;
        for (int c = 0; c <= lat + 1; c++) begin
            if (c == 0) chk("div_zero_at_accept", div_zero, edz);
            if (c == 1) chk("busy_c1", busy, (lat > 1));
            if ((c == lat - 1) && (lat > 1)) chk("busy_last", busy, 1'b1);
            if (c == lat) chk("busy_at_done", busy, 1'b0);
            if (c == lat + 1) begin
                chk("done_seen", sb_q.size(), 0);
                sb_q.delete();
            end
            if (c == poke_cyc) begin
                start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (c == rst_cyc) begin
                reset = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_done", done, 1'b0);
                chk("rst_hi", hi, 32'd0);
                chk("rst_lo", lo, 32'd0);
                @(negedge clk);
                @(negedge clk);
                reset = 1'b1;
                repeat (40) @(negedge clk);
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        chk("reset_dz", div_zero, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        do_op(OP_MULT, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, -1, -1);
        do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, -1, -1);
        do_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, -1, -1);
        do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, -1, -1);
        do_op(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, -1, -1);
        do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, -1, -1);
        do_op(OP_DIV,  32'd5,         32'd2,         32'h0000_0001, 32'h0000_0002, 1'b0, -1, -1);
        do_op(OP_DIV,  32'd5,         32'd0,         32'h0000_0001, 32'h0000_0002, 1'b1, -1, -1);
        do_op(OP_MULT, 32'd2,         32'd3,         32'h0000_0000, 32'h0000_0006, 1'b0, -1, -1);
        do_op(OP_MULT, 32'd3,         32'd4,         32'h0000_0000, 32'h0000_000C, 1'b0, 10, -1);
        repeat (40) @(negedge clk);
        do_op(OP_DIV,  32'd100,       32'd7,         32'h0000_0000, 32'h0000_0000, 1'b0, -1, 15);
        do_op(OP_DIV,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, -1, -1);
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
